lcd_hd44780_driver: RTL and testbench
=====================================

LCD_HD44780_DRIVER -- requirements
Module: lcd_hd44780_driver

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 10, meaning RS/DB setup before E rise and hold after E fall, in clocks.
REQ-002 SHALL have parameter E_PULSE_CYC, default 50, meaning E high width in clocks.
REQ-003 SHALL have parameter CMD_WAIT_CYC, default 4000, meaning post-byte wait (40 us at 100 MHz).
REQ-004 SHALL have parameter CLR_WAIT_CYC, default 160000, meaning post-wait for commands 0x01/0x02/0x03.
REQ-005 SHALL have parameter PWRUP_WAIT_CYC, default 1500000, meaning delay after reset before the first nibble.
REQ-006 SHALL have parameter INIT_WAIT_CYC, default 410000, meaning wait after the first init nibble.
REQ-007 SHALL have port ACLK, input, 1 bit: the single clock; all logic rising-edge.
REQ-008 SHALL have port ARESETN, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have port in_valid, input, 1 bit: byte request from the AXI-Lite register stage.
REQ-010 SHALL have port in_ready, output, 1 bit: driver accepts a byte this cycle.
REQ-011 SHALL have port in_rs, input, 1 bit: 0 = command, 1 = character data.
REQ-012 SHALL have port in_byte, input, 8 bits: byte to send.
REQ-013 SHALL have port init_done, output, 1 bit: init sequence complete.
REQ-014 SHALL have port busy, output, 1 bit: equals NOT in_ready.
REQ-015 SHALL have port lcd_rs, output, 1 bit; port lcd_rw, output, 1 bit, constant 0; port lcd_e, output, 1 bit; port lcd_db, output, 4 bits (DB7..DB4).

Function
REQ-016 SHALL use one 24-bit down-counter for all delays; parameters SHALL be 1..2^24-1.
REQ-017 SHALL implement states PWRUP, INIT_NIB, INIT_BYTE, IDLE, SETUP, E_HIGH, HOLD, WAIT.
REQ-018 SHALL, after reset release, hold lcd_e=0 for exactly PWRUP_WAIT_CYC clocks.
REQ-019 SHALL then send single nibbles 0x3, 0x3, 0x3, 0x2, waiting INIT_WAIT_CYC after the first and CMD_WAIT_CYC after each of the others.
REQ-020 SHALL then send full bytes (rs=0) 0x28, 0x0C, 0x01, 0x06, then assert init_done=1 and enter IDLE.
REQ-021 SHALL assert in_ready only in IDLE with init_done=1; a transfer is accepted on the cycle in_valid&&in_ready, latching in_rs and in_byte.
REQ-022 Nibble timing, with acceptance at cycle T: lcd_rs and lcd_db = byte[7:4] valid from T+1.
REQ-023 lcd_e SHALL be high from T+1+SETUP_CYC for exactly E_PULSE_CYC clocks.
REQ-024 Hold SHALL last SETUP_CYC clocks; the low nibble [3:0] SHALL then repeat REQ-023 timing, offset by P = 2*SETUP_CYC + E_PULSE_CYC.
REQ-025 SHALL wait W after the second hold, where W = CLR_WAIT_CYC if rs=0 and byte is 0x01, 0x02 or 0x03, else CMD_WAIT_CYC.
REQ-026 in_ready SHALL reassert at exactly T+1+2P+W.
REQ-027 lcd_rs and lcd_db SHALL remain stable throughout each E-high window and its hold.
REQ-028 in_valid while in_ready=0 (including during init) SHALL be ignored, not queued; a held in_valid is accepted on the first cycle in_ready=1.
REQ-029 Init-sequence nibbles SHALL use the same SETUP/E/HOLD timing with lcd_rs=0.

Reset
REQ-030 While ARESETN=0: lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_db=0, in_ready=0, init_done=0, busy=1, counter=0, state=PWRUP; asynchronous, effective mid-transfer.
REQ-031 On ARESETN release, the full power-up and init sequence SHALL restart from PWRUP.

Verification (params SETUP=2, E_PULSE=3, CMD_WAIT=8, CLR_WAIT=20, PWRUP=30, INIT_WAIT=12; P=7)
REQ-032 Reset release -> lcd_e low 30 clocks; then 12 E pulses latching nibbles 3,3,3,2,2,8,0,C,0,1,0,6 with lcd_rs=0; then init_done=1.
REQ-033 After init, in_rs=1, in_byte=0x41 accepted at T -> E pulses at T+3..T+5 (db=4) and T+10..T+12 (db=1); lcd_rs=1; in_ready=1 at T+23.
REQ-034 Command 0x01 accepted at T -> in_ready=1 at T+35; command 0x80 -> in_ready=1 at T+23.
REQ-035 in_valid=1 held from reset release -> no acceptance before init_done; first byte accepted the cycle init_done rises, then next at +23.
REQ-036 ARESETN pulsed low while lcd_e=1 -> lcd_e=0 within the same cycle, init_done=0; after release a fresh 30-clock power-up wait precedes the 0x3 nibble.

Source files
------------

// File: rtl/lcd_hd44780_driver.sv
// rtl/lcd_hd44780_driver.sv - HD44780 4-bit LCD write driver with power-up init sequence
module lcd_hd44780_driver #(
    parameter int SETUP_CYC      = 10,
    parameter int E_PULSE_CYC    = 50,
    parameter int CMD_WAIT_CYC   = 4000,
    parameter int CLR_WAIT_CYC   = 160000,
    parameter int PWRUP_WAIT_CYC = 1500000,
    parameter int INIT_WAIT_CYC  = 410000
) (
    input  logic       ACLK,
    input  logic       ARESETN,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_rs,
    input  logic [7:0] in_byte,
    output logic       init_done,
    output logic       busy,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [3:0] lcd_db
);

    localparam logic [23:0] SETUP_LD = 24'(SETUP_CYC - 1);
    localparam logic [23:0] E_LD     = 24'(E_PULSE_CYC - 1);
    localparam logic [23:0] CMD_LD   = 24'(CMD_WAIT_CYC - 1);
    localparam logic [23:0] CLR_LD   = 24'(CLR_WAIT_CYC - 1);
    localparam logic [23:0] PWRUP_LD = 24'(PWRUP_WAIT_CYC - 1);
    localparam logic [23:0] INIT_LD  = 24'(INIT_WAIT_CYC - 1);

    typedef enum logic [2:0] {
        PWRUP, INIT_NIB, INIT_BYTE, IDLE, SETUP, E_HIGH, HOLD, WAIT
    } state_t;

    state_t      state;
    logic [23:0] cnt;
    logic        pwrup_armed;   // first cycle after reset loads the power-up delay
    logic [2:0]  init_idx;      // 0..3 init nibbles, 4..7 init bytes
    logic        single;        // current transfer is a lone init nibble
    logic        second;        // low nibble of a byte is on the bus
    logic        cur_rs;
    logic [7:0]  cur_byte;
    logic [7:0]  init_byte;
    logic        is_clr;

    assign lcd_rw = 1'b0;
    assign busy   = ~in_ready;

    // Function-set, display-on, clear, entry-mode bytes of the init sequence
    always_comb begin
        init_byte = 8'h28;
        case (init_idx[1:0])
            2'd0:    init_byte = 8'h28;
            2'd1:    init_byte = 8'h0C;
            2'd2:    init_byte = 8'h01;
            default: init_byte = 8'h06;
        endcase
    end

    // Clear / home commands need the long post-wait
    always_comb begin
        is_clr = ~cur_rs && (cur_byte[7:2] == 6'd0) && (cur_byte[1:0] != 2'd0);
    end

    // Main sequencer: power-up, init nibbles/bytes, then host byte transfers
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state       <= PWRUP;
            cnt         <= 24'd0;
            pwrup_armed <= 1'b0;
            init_idx    <= 3'd0;
            single      <= 1'b0;
            second      <= 1'b0;
            cur_rs      <= 1'b0;
            cur_byte    <= 8'h00;
            in_ready    <= 1'b0;
            init_done   <= 1'b0;
            lcd_rs      <= 1'b0;
            lcd_e       <= 1'b0;
            lcd_db      <= 4'h0;
        end else begin
            case (state)
                PWRUP: begin
                    if (!pwrup_armed) begin
                        pwrup_armed <= 1'b1;
                        cnt         <= PWRUP_LD;
                    end else if (cnt != 24'd0) begin
                        cnt <= cnt - 24'd1;
                    end else begin
                        state <= INIT_NIB;
                    end
                end
                INIT_NIB: begin
                    single   <= 1'b1;
                    second   <= 1'b0;
                    cur_rs   <= 1'b0;
                    cur_byte <= 8'h00;
                    lcd_rs   <= 1'b0;
                    lcd_db   <= (init_idx == 3'd3) ? 4'h2 : 4'h3;
                    cnt      <= SETUP_LD;
                    state    <= SETUP;
                end
                INIT_BYTE: begin
                    single   <= 1'b0;
                    second   <= 1'b0;
                    cur_rs   <= 1'b0;
                    cur_byte <= init_byte;
                    lcd_rs   <= 1'b0;
                    lcd_db   <= init_byte[7:4];
                    cnt      <= SETUP_LD;
                    state    <= SETUP;
                end
                IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        single   <= 1'b0;
                        second   <= 1'b0;
                        cur_rs   <= in_rs;
                        cur_byte <= in_byte;
                        lcd_rs   <= in_rs;
                        lcd_db   <= in_byte[7:4];
                        cnt      <= SETUP_LD;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt != 24'd0) begin
                        cnt <= cnt - 24'd1;
                    end else begin
                        lcd_e <= 1'b1;
                        cnt   <= E_LD;
                        state <= E_HIGH;
                    end
                end
                E_HIGH: begin
                    if (cnt != 24'd0) begin
                        cnt <= cnt - 24'd1;
                    end else begin
                        lcd_e <= 1'b0;
                        cnt   <= SETUP_LD;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (cnt != 24'd0) begin
                        cnt <= cnt - 24'd1;
                    end else if (!single && !second) begin
                        second <= 1'b1;
                        lcd_db <= cur_byte[3:0];
                        cnt    <= SETUP_LD;
                        state  <= SETUP;
                    end else begin
                        if (single)
                            cnt <= (init_idx == 3'd0) ? INIT_LD : CMD_LD;
                        else
                            cnt <= is_clr ? CLR_LD : CMD_LD;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != 24'd0) begin
                        cnt <= cnt - 24'd1;
                    end else if (init_done || init_idx == 3'd7) begin
                        init_done <= 1'b1;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        init_idx <= init_idx + 3'd1;
                        state    <= (init_idx < 3'd3) ? INIT_NIB : INIT_BYTE;
                    end
                end
                default: state <= PWRUP;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_hd44780_driver.sv
// tb/tb_lcd_hd44780_driver.sv - directed self-checking bench for lcd_hd44780_driver
module tb_lcd_hd44780_driver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       in_rs = 1'b0;
    logic [7:0] in_byte = 8'h00;
    logic       init_done;
    logic       busy;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [3:0] lcd_db;

    int checks = 0;
    int errors = 0;

    lcd_hd44780_driver #(
        .SETUP_CYC(2), .E_PULSE_CYC(3), .CMD_WAIT_CYC(8),
        .CLR_WAIT_CYC(20), .PWRUP_WAIT_CYC(30), .INIT_WAIT_CYC(12)
    ) dut (
        .ACLK(clk), .ARESETN(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_rs(in_rs), .in_byte(in_byte),
        .init_done(init_done), .busy(busy),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_db(lcd_db)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Follows a full power-up/init, capturing the nibble on each E rise
    task automatic run_init(input string tag);
        logic [3:0] nib[12];
        logic [3:0] exp_nib[12];
        int         np;
        logic       prev_e;
        logic       early_e;
        logic       rs_hi;
        logic       early_ready;
        exp_nib = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'hC, 4'h0, 4'h1, 4'h0, 4'h6};
        np = 0; prev_e = 1'b0; early_e = 1'b0; rs_hi = 1'b0; early_ready = 1'b0;
        for (int i = 0; i < 12; i++) nib[i] = 4'h0;
        for (int k = 1; k <= 3000; k++) begin
            @(negedge clk);
            if (k <= 30 && lcd_e) early_e = 1'b1;
            if (!init_done && in_ready) early_ready = 1'b1;
            if (lcd_e && !prev_e) begin
                if (np < 12) nib[np] = lcd_db;
                if (lcd_rs) rs_hi = 1'b1;
                np++;
            end
            prev_e = lcd_e;
            if (init_done) break;
        end
        chk({tag, "_init_done"}, 32'(init_done), 32'd1);
        chk({tag, "_pwrup_e_low"}, 32'(early_e), 32'd0);
        chk({tag, "_pulse_count"}, 32'(np), 32'd12);
        chk({tag, "_init_rs"}, 32'(rs_hi), 32'd0);
        chk({tag, "_ready_before_init"}, 32'(early_ready), 32'd0);
        for (int i = 0; i < 12; i++)
            chk($sformatf("%s_nib%0d", tag, i), 32'(nib[i]), 32'(exp_nib[i]));
    endtask

    // Sends one byte and checks the cycle at which in_ready returns
    task automatic send_measure(input string tag, input logic rs, input logic [7:0] b, input int exp_k);
        int k;
        for (int w = 0; w < 500 && !in_ready; w++) @(negedge clk);
        in_rs = rs; in_byte = b; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        k = 0;
        for (int j = 1; j <= 500; j++) begin
            @(negedge clk);
            if (in_ready) begin k = j; break; end
        end
        chk(tag, 32'(k), 32'(exp_k));
    endtask

    initial begin
        // Reset values
        #1;
        chk("rst_e", 32'(lcd_e), 32'd0);
        chk("rst_rs", 32'(lcd_rs), 32'd0);
        chk("rst_rw", 32'(lcd_rw), 32'd0);
        chk("rst_db", 32'(lcd_db), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        run_init("boot");
        chk("boot_ready", 32'(in_ready), 32'd1);
        chk("boot_busy", 32'(busy), 32'd0);

        // Character 'A' with cycle-by-cycle waveform check
        @(negedge clk);
        in_rs = 1'b1; in_byte = 8'h41; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        for (int k = 1; k <= 23; k++) begin
            @(negedge clk);
            chk($sformatf("char_e@T+%0d", k), 32'(lcd_e),
                32'(((k >= 3 && k <= 5) || (k >= 10 && k <= 12)) ? 1 : 0));
            if (k <= 14)
                chk($sformatf("char_db@T+%0d", k), 32'(lcd_db), (k <= 7) ? 32'h4 : 32'h1);
            chk($sformatf("char_rs@T+%0d", k), 32'(lcd_rs), 32'd1);
            chk($sformatf("char_ready@T+%0d", k), 32'(in_ready), (k == 23) ? 32'd1 : 32'd0);
        end
        chk("char_rw", 32'(lcd_rw), 32'd0);

        // Clear uses the long wait, set-DDRAM uses the short one
        send_measure("clear_ready_delay", 1'b0, 8'h01, 35);
        send_measure("home_ready_delay", 1'b0, 8'h02, 35);
        send_measure("ddram_ready_delay", 1'b0, 8'h80, 23);
        send_measure("data01_ready_delay", 1'b1, 8'h01, 23);

        // in_valid held through reset and init
        @(negedge clk);
        rst_n = 1'b0;
        in_rs = 1'b1; in_byte = 8'h41; in_valid = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_init("held");
        chk("held_ready_at_init", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk("held_first_accept", 32'(in_ready), 32'd0);
        repeat (21) @(negedge clk);
        chk("held_ready_T+22", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("held_ready_T+23", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk("held_second_accept", 32'(in_ready), 32'd0);
        in_valid = 1'b0;

        // Asynchronous reset in the middle of an E pulse
        for (int w = 0; w < 200 && !lcd_e; w++) @(negedge clk);
        chk("mid_e_high", 32'(lcd_e), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_e", 32'(lcd_e), 32'd0);
        chk("mid_rst_init_done", 32'(init_done), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd1);
        chk("mid_rst_db", 32'(lcd_db), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_init("rerun");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound so a stuck design still ends the run
    initial begin
        #200000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
